uart_cfg_ctrl: RTL and testbench

UART_CFG_CTRL -- requirements
Module: uart_cfg_ctrl

---
 rtl/uart_cfg_ctrl_pkg.sv | 48 ++++
 rtl/uart_cfg_ctrl.sv | 165 ++++++++++++++++
 tb/tb_uart_cfg_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cfg_ctrl_pkg.sv
// Shared UART configuration definitions: timing constants, handshake bytes,
// controller state encoding and the line-format field encodings.
package uart_cfg_ctrl_pkg;

    localparam int SYSTEM_CLOCK_FREQ = 50_000_000;
    localparam int COUNT_10MS        = SYSTEM_CLOCK_FREQ / 100;

    localparam logic [1:0] CFG_HEADER = 2'b10;
    localparam logic [7:0] CFG_ACK    = 8'h06;
    localparam logic [7:0] CFG_NACK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_LOW,
        ST_SEND_CFG,
        ST_WAIT_ACK,
        ST_SLV_WAIT_CFG,
        ST_SLV_SEND_RSP
    } cfg_state_t;

    localparam logic [1:0] DW_5BIT = 2'b00;
    localparam logic [1:0] DW_6BIT = 2'b01;
    localparam logic [1:0] DW_7BIT = 2'b10;
    localparam logic [1:0] DW_8BIT = 2'b11;

    localparam logic [1:0] SB_1BIT  = 2'b00;
    localparam logic [1:0] SB_15BIT = 2'b01;
    localparam logic [1:0] SB_2BIT  = 2'b10;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;
    localparam logic [1:0] PARITY_MARK = 2'b11;

    // Field order matches bits [5:0] of the configuration byte.
    typedef struct packed {
        logic [1:0] data_width;
        logic [1:0] stop_bits;
        logic [1:0] parity;
    } uart_cfg_t;

    localparam uart_cfg_t CFG_DEFAULT = '{data_width: DW_8BIT, stop_bits: SB_1BIT, parity: PARITY_NONE};

    function automatic logic [7:0] cfg_byte(input uart_cfg_t c);
        return {CFG_HEADER, c};
    endfunction

endpackage

// File: rtl/uart_cfg_ctrl.sv
// UART line-configuration handshake controller (master request and slave response).
// Optional build macro CFG_TIMEOUT_EN: abort reply waits after one 10 ms interval.
module uart_cfg_ctrl
    import uart_cfg_ctrl_pkg::*;
#(
    parameter int COUNT_10MS_P = COUNT_10MS
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cfg_start_i,
    input  logic [1:0] cfg_data_width_i,
    input  logic [1:0] cfg_stop_bits_i,
    input  logic [1:0] cfg_parity_i,
    input  logic       cfg_req_slv_i,
    input  logic       rx_done_i,
    input  logic [7:0] rx_data_i,
    input  logic       tx_done_i,
    output logic       tx_req_o,
    output logic [7:0] tx_data_o,
    output logic       tx_force_low_o,
    output logic [1:0] data_width_o,
    output logic [1:0] stop_bits_o,
    output logic [1:0] parity_mode_o,
    output logic       cfg_busy_o,
    output logic       cfg_done_o,
    output logic       cfg_error_o
);

    localparam int CNT_W = (COUNT_10MS_P > 1) ? $clog2(COUNT_10MS_P) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_10MS_P - 1);

    cfg_state_t       state_reg;
    uart_cfg_t        active_reg;
    uart_cfg_t        pending_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             rsp_ack_reg;

    assign data_width_o  = active_reg.data_width;
    assign stop_bits_o   = active_reg.stop_bits;
    assign parity_mode_o = active_reg.parity;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg      <= ST_IDLE;
            active_reg     <= CFG_DEFAULT;
            pending_reg    <= '0;
            cnt_reg        <= '0;
            rsp_ack_reg    <= 1'b0;
            tx_req_o       <= 1'b0;
            tx_data_o      <= 8'h00;
            tx_force_low_o <= 1'b0;
            cfg_busy_o     <= 1'b0;
            cfg_done_o     <= 1'b0;
            cfg_error_o    <= 1'b0;
        end else begin
            tx_req_o    <= 1'b0;
            cfg_done_o  <= 1'b0;
            cfg_error_o <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // A remote request takes priority over a local start in the same cycle.
                    if (cfg_req_slv_i) begin
                        state_reg  <= ST_SLV_WAIT_CFG;
                        cnt_reg    <= '0;
                        cfg_busy_o <= 1'b1;
                    end else if (cfg_start_i) begin
                        pending_reg    <= '{data_width: cfg_data_width_i,
                                            stop_bits:  cfg_stop_bits_i,
                                            parity:     cfg_parity_i};
                        cnt_reg        <= '0;
                        state_reg      <= ST_REQ_LOW;
                        tx_force_low_o <= 1'b1;
                        cfg_busy_o     <= 1'b1;
                    end
                end

                ST_REQ_LOW: begin
                    if (cnt_reg == CNT_LAST) begin
                        tx_force_low_o <= 1'b0;
                        tx_req_o       <= 1'b1;
                        tx_data_o      <= cfg_byte(pending_reg);
                        state_reg      <= ST_SEND_CFG;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_SEND_CFG: begin
                    if (tx_done_i) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (rx_done_i) begin
                        if (rx_data_i == CFG_ACK) begin
                            active_reg <= pending_reg;
                            cfg_done_o <= 1'b1;
                        end else begin
                            cfg_error_o <= 1'b1;
                        end
                        state_reg  <= ST_IDLE;
                        cfg_busy_o <= 1'b0;
                    end
`ifdef CFG_TIMEOUT_EN
                    else if (cnt_reg == CNT_LAST) begin
                        cfg_error_o <= 1'b1;
                        state_reg   <= ST_IDLE;
                        cfg_busy_o  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`endif
                end

                ST_SLV_WAIT_CFG: begin
                    if (rx_done_i) begin
                        if (rx_data_i[7:6] == CFG_HEADER) begin
                            pending_reg <= uart_cfg_t'(rx_data_i[5:0]);
                            rsp_ack_reg <= 1'b1;
                            tx_data_o   <= CFG_ACK;
                        end else begin
                            rsp_ack_reg <= 1'b0;
                            tx_data_o   <= CFG_NACK;
                        end
                        tx_req_o  <= 1'b1;
                        state_reg <= ST_SLV_SEND_RSP;
                    end
`ifdef CFG_TIMEOUT_EN
                    else if (cnt_reg == CNT_LAST) begin
                        cfg_error_o <= 1'b1;
                        state_reg   <= ST_IDLE;
                        cfg_busy_o  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`endif
                end

                ST_SLV_SEND_RSP: begin
                    // New settings take effect only once the response byte has left the line.
                    if (tx_done_i) begin
                        if (rsp_ack_reg) begin
                            active_reg <= pending_reg;
                            cfg_done_o <= 1'b1;
                        end else begin
                            cfg_error_o <= 1'b1;
                        end
                        state_reg  <= ST_IDLE;
                        cfg_busy_o <= 1'b0;
                    end
                end

                default: begin
                    state_reg      <= ST_IDLE;
                    tx_force_low_o <= 1'b0;
                    cfg_busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Randomized self-checking bench for uart_cfg_ctrl against a transaction-level model.
// Handles builds with and without CFG_TIMEOUT_EN.
module tb_uart_cfg_ctrl;
    import uart_cfg_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic [1:0] cfg_dw = '0, cfg_sb = '0, cfg_par = '0;
    logic       cfg_req_slv = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = '0;
    logic       tx_done = 1'b0;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_force_low;
    logic [1:0] dw_out, sb_out, par_out;
    logic       busy, done, error;

    int checks = 0;
    int errors = 0;

    // Reference model: the active line configuration as seen by the datapath.
    logic [5:0] m_cfg;

    uart_cfg_ctrl #(.COUNT_10MS_P(10)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .cfg_start_i      (cfg_start),
        .cfg_data_width_i (cfg_dw),
        .cfg_stop_bits_i  (cfg_sb),
        .cfg_parity_i     (cfg_par),
        .cfg_req_slv_i    (cfg_req_slv),
        .rx_done_i        (rx_done),
        .rx_data_i        (rx_data),
        .tx_done_i        (tx_done),
        .tx_req_o         (tx_req),
        .tx_data_o        (tx_data),
        .tx_force_low_o   (tx_force_low),
        .data_width_o     (dw_out),
        .stop_bits_o      (sb_out),
        .parity_mode_o    (par_out),
        .cfg_busy_o       (busy),
        .cfg_done_o       (done),
        .cfg_error_o      (error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cfg(input string tag);
        check_val(tag, {26'd0, dw_out, sb_out, par_out}, {26'd0, m_cfg});
    endtask

    // Start as master and run up to the point where the controller awaits the reply.
    task automatic master_begin(input logic [1:0] dw, input logic [1:0] sb, input logic [1:0] par);
        int n;
        cfg_dw = dw; cfg_sb = sb; cfg_par = par;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n = 0;
        while (tx_force_low === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        check_val("force_low_len", n, 10);
        check_val("m_tx_req", tx_req, 1);
        check_val("m_tx_data", tx_data, {24'd0, 2'b10, dw, sb, par});
        check_val("m_busy", busy, 1);
        tick();
        check_val("m_tx_req_once", tx_req, 0);
        // A start request while busy must be ignored.
        cfg_dw = ~dw; cfg_sb = ~sb; cfg_par = ~par;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic master_txn(input logic [1:0] dw, input logic [1:0] sb, input logic [1:0] par,
                              input logic [7:0] reply);
        master_begin(dw, sb, par);
        repeat ($urandom_range(0, 5)) tick();
        check_cfg("m_cfg_hold");
        rx_data = reply;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        if (reply == 8'h06) m_cfg = {dw, sb, par};
        check_val("m_done", done, (reply == 8'h06));
        check_val("m_error", error, (reply != 8'h06));
        check_cfg("m_cfg_after");
        tick();
        check_val("m_done_once", done | error, 0);
        check_val("m_idle", busy, 0);
        $display("master dw=%0d sb=%0d par=%0d reply=%02h -> cfg=%02h", dw, sb, par, reply, m_cfg);
    endtask

    task automatic slave_txn(input logic [7:0] rx, input bit collide);
        logic seen_low;
        logic [7:0] exp_rsp;
        if (collide) begin
            cfg_dw = 2'($urandom); cfg_sb = 2'($urandom); cfg_par = 2'($urandom);
            cfg_start = 1'b1;
            cfg_req_slv = 1'b1;
            tick();
            cfg_start = 1'b0;
            cfg_req_slv = 1'b0;
            seen_low = tx_force_low;
            repeat (3) begin
                tick();
                seen_low = seen_low | tx_force_low;
            end
            check_val("col_force_low", seen_low, 0);
        end else begin
            cfg_req_slv = 1'b1;
            tick();
            cfg_req_slv = 1'b0;
        end
        check_val("s_busy", busy, 1);
        repeat ($urandom_range(0, 4)) tick();
        rx_data = rx;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        exp_rsp = (rx[7:6] == 2'b10) ? 8'h06 : 8'h15;
        check_val("s_tx_req", tx_req, 1);
        check_val("s_tx_data", tx_data, exp_rsp);
        tick();
        check_val("s_tx_req_once", tx_req, 0);
        repeat ($urandom_range(0, 4)) tick();
        check_cfg("s_cfg_hold");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (rx[7:6] == 2'b10) m_cfg = rx[5:0];
        check_val("s_done", done, (rx[7:6] == 2'b10));
        check_val("s_error", error, (rx[7:6] != 2'b10));
        check_cfg("s_cfg_after");
        check_val("s_idle", busy, 0);
        tick();
        $display("slave rx=%02h collide=%0d rsp=%02h -> cfg=%02h", rx, collide, exp_rsp, m_cfg);
    endtask

    task automatic idle_noise();
        rx_data = 8'($urandom);
        rx_done = 1'b1;
        tx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tx_done = 1'b0;
        tick();
        check_val("idle_busy", busy, 0);
        check_val("idle_pulses", {tx_req, done, error}, 0);
        check_cfg("idle_cfg");
        $display("idle noise rx=%02h ignored", rx_data);
    endtask

    task automatic timeout_test();
        int n;
        master_begin(DW_6BIT, SB_15BIT, PARITY_EVEN);
`ifdef CFG_TIMEOUT_EN
        n = 0;
        do begin
            tick();
            n++;
        end while (error !== 1'b1 && n < 50);
        check_val("timeout_cycles", n, 10);
        check_val("timeout_idle", busy, 0);
        check_cfg("timeout_cfg");
        $display("timeout after %0d cycles", n);
`else
        repeat (1000) tick();
        check_val("no_timeout_busy", busy, 1);
        check_val("no_timeout_error", error, 0);
        rx_data = 8'h15;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        check_val("no_timeout_exit", error, 1);
        check_cfg("no_timeout_cfg");
        $display("no timeout: still busy after 1000 cycles");
`endif
        tick();
    endtask

    task automatic reset_test();
        logic seen;
        cfg_dw = DW_5BIT; cfg_sb = SB_2BIT; cfg_par = PARITY_MARK;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        repeat (3) tick();
        check_val("rst_pre_low", tx_force_low, 1);
        rst_n = 1'b0;
        tick();
        m_cfg = {DW_8BIT, SB_1BIT, PARITY_NONE};
        check_val("rst_force_low", tx_force_low, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_pulses", {tx_req, done, error}, 0);
        check_val("rst_tx_data", tx_data, 0);
        check_cfg("rst_cfg");
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            seen = seen | done | error | tx_force_low | busy;
        end
        check_val("rst_quiet", seen, 0);
        $display("reset in REQ_LOW aborted cleanly");
    endtask

    initial begin
        logic [7:0] b;
        m_cfg = {DW_8BIT, SB_1BIT, PARITY_NONE};
        repeat (3) tick();
        check_val("reset_busy", busy, 0);
        check_val("reset_outs", {tx_req, tx_force_low, done, error}, 0);
        check_val("reset_tx_data", tx_data, 0);
        check_cfg("reset_cfg");
        rst_n = 1'b1;
        tick();

        master_txn(DW_7BIT, SB_2BIT, PARITY_ODD, 8'h15);
        master_txn(DW_7BIT, SB_2BIT, PARITY_ODD, 8'h06);
        slave_txn({2'b10, DW_5BIT, SB_1BIT, PARITY_EVEN}, 1'b0);
        slave_txn(8'h3F, 1'b0);
        slave_txn({2'b10, DW_6BIT, SB_2BIT, PARITY_ODD}, 1'b1);
        idle_noise();

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0: master_txn(2'($urandom), 2'($urandom), 2'($urandom), 8'h06);
                1: begin
                    b = 8'($urandom);
                    if (b == 8'h06) b = 8'h15;
                    master_txn(2'($urandom), 2'($urandom), 2'($urandom), b);
                end
                2: slave_txn({2'b10, 6'($urandom)}, 1'($urandom));
                3: begin
                    b = 8'($urandom);
                    if (b[7:6] == 2'b10) b[7] = 1'b0;
                    slave_txn(b, 1'($urandom));
                end
                default: idle_noise();
            endcase
        end

        timeout_test();
        reset_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
